deal_sequencer: RTL and testbench
=================================

// Module: deal_sequencer
// PURPOSE
//  Controller that sequences the baccarat card datapath. One step pulse deals
//  one card in the order P1,D1,P2,D2, then applies the third-card rules.
//  Drives load_pcard1..3/load_dcard1..3, reads back pscore/dscore/pcard3, and
//  latches the winner lights. Sits between the debounced key logic and datapath.
// PARAMETERS
//  CARD_W   4  width of card rank (1..13; 0 = no card)
//  SCORE_W  4  width of score inputs (0..9)
// PORTS
//  clk          in   1        system clock; all state on rising edge
//  reset        in   1        synchronous, active-high; one clock, no other clocks
//  step         in   1        one-cycle advance pulse (already debounced/synced)
//  pscore       in   SCORE_W  player score from datapath
//  dscore       in   SCORE_W  dealer score from datapath
//  pcard3       in   CARD_W   player third-card rank from datapath
//  load_pcard1  out  1        load strobes to datapath (load_pcard2/3, load_dcard1..3
//  ...          out  1        identical), one-hot, at most one high per cycle
//  player_win   out  1        player-wins light (both lights = tie)
//  dealer_win   out  1        dealer-wins light
//  done         out  1        high while in S_DONE
// BEHAVIOUR
//  States: S_P1(reset) S_D1 S_P2 S_D2 S_DEC1 S_P3 S_DEC2 S_D3 S_SCORE S_DONE.
//  Load strobes: Mealy, zero latency: load_X = (state==S_X) & step & !reset.
//   Datapath captures on the same edge the FSM leaves S_X; scores are valid in
//   the next state. Strobes are 0 in all other states and during reset.
//  S_P1->S_D1->S_P2->S_D2->S_DEC1, each transition only on step.
//  S_DEC1 (1 cycle, ignores step):
//   pscore>=8 or dscore>=8 (natural)  -> S_SCORE
//   else pscore<=5                    -> S_P3
//   else dscore<=5                    -> S_D3
//   else                              -> S_SCORE
//  S_P3: step -> load_pcard3, -> S_DEC2.
//  S_DEC2 (1 cycle, ignores step): v = value(pcard3) (rank>=10 -> 0, else rank).
//   dealer draws (-> S_D3) if: dscore<=2; dscore==3 & v!=8; dscore==4 & v in 2..7;
//   dscore==5 & v in 4..7; dscore==6 & v in 6..7. Otherwise (incl. 7) -> S_SCORE.
//  S_D3: step -> load_dcard3, -> S_SCORE.
//  S_SCORE (1 cycle): register player_win = pscore>=dscore,
//   dealer_win = dscore>=pscore; -> S_DONE.
//  S_DONE: holds lights, done=1; step ignored; exit only by reset.
//  Reset: state=S_P1, player_win=dealer_win=0, done=0. Reset wins over a
//   coincident step (no strobe). Reset mid-hand aborts immediately; caller
//   resets datapath on the same cycle.
//  Step in one-cycle states is dropped, not queued.
//  Scores compared unsigned 4-bit; inputs >9 are out of contract.
// STRUCTURE
//  baccarat_pkg: state_t enum, card_value() function, constants
//   NATURAL_MIN=8, PLAYER_DRAW_MAX=5, DEALER_DRAW_MAX=5.
//  Sub-module banker_draw_rule (combinational: dscore, v -> draw) holds the
//   S_DEC2 table; instantiated once.
// TESTING
//  Bench has a behavioural card/score model driving pscore/dscore/pcard3.
//  1 reset then 4 steps -> strobes pcard1,dcard1,pcard2,dcard2 each 1 cycle in
//   order; no strobe without step; reset+step same cycle -> no strobe.
//  Natural: pscore=8,dscore=3 after D2 -> no P3/D3 strobe, player_win=1,
//   dealer_win=0, done=1 two cycles after D2 strobe.
//  Player stands, dealer draws: pscore=6,dscore=4 -> next step strobes dcard3
//   only; dscore=9 then -> dealer_win=1.
//  Banker table sweep: pscore=3 -> P3; pcard3 in {2,4,6,8,12} x dscore 0..7
//   -> dcard3 strobe exactly per table (e.g. dscore=6,rank=12 -> stand).
//  Tie: final pscore=dscore=7 -> both lights 1; steps in S_DONE change nothing.
//  Reset in S_P3 -> state S_P1, lights 0, next step strobes load_pcard1.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat deal controller: FSM states,
// card value mapping and the drawing-rule thresholds.
package baccarat_pkg;

  typedef enum logic [3:0] {
    StP1,
    StD1,
    StP2,
    StD2,
    StDec1,
    StP3,
    StDec2,
    StD3,
    StScore,
    StDone
  } state_t;

  localparam logic [3:0] NATURAL_MIN     = 4'd8;
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;
  localparam logic [3:0] DEALER_DRAW_MAX = 4'd5;

  // Tens and face cards count as zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank >= 4'd10) ? 4'd0 : rank;
  endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// Dealer third-card decision, used once the player has drawn a third card.
// Purely combinational: dealer score and player third-card value in, draw out.
module banker_draw_rule #(
  parameter int unsigned SCORE_W = 4
) (
  input  logic [SCORE_W-1:0] dscore,
  input  logic [3:0]         v,
  output logic               draw
);

  always_comb begin
    draw = 1'b0;
    case (dscore)
      SCORE_W'(0), SCORE_W'(1), SCORE_W'(2): draw = 1'b1;
      SCORE_W'(3): draw = (v != 4'd8);
      SCORE_W'(4): draw = (v >= 4'd2) && (v <= 4'd7);
      SCORE_W'(5): draw = (v >= 4'd4) && (v <= 4'd7);
      SCORE_W'(6): draw = (v >= 4'd6) && (v <= 4'd7);
      default:     draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/deal_sequencer.sv
// Baccarat deal controller: steps the datapath through P1,D1,P2,D2, applies
// the third-card rules and latches the winner lights.
module deal_sequencer
  import baccarat_pkg::*;
#(
  parameter int unsigned CARD_W  = 4,
  parameter int unsigned SCORE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic [SCORE_W-1:0] pscore,
  input  logic [SCORE_W-1:0] dscore,
  input  logic [CARD_W-1:0]  pcard3,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               player_win,
  output logic               dealer_win,
  output logic               done
);

  state_t     state_q;
  logic       dealer_draw;
  logic [3:0] pcard3_value;
  logic       adv;

  assign pcard3_value = card_value(pcard3);

  banker_draw_rule #(
    .SCORE_W(SCORE_W)
  ) u_banker_draw_rule (
    .dscore(dscore),
    .v     (pcard3_value),
    .draw  (dealer_draw)
  );

  // Strobes are Mealy so the datapath captures on the edge that leaves the state.
  assign adv = step & ~reset;

  always_comb begin
    load_pcard1 = adv && (state_q == StP1);
    load_dcard1 = adv && (state_q == StD1);
    load_pcard2 = adv && (state_q == StP2);
    load_dcard2 = adv && (state_q == StD2);
    load_pcard3 = adv && (state_q == StP3);
    load_dcard3 = adv && (state_q == StD3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StP1;
      player_win <= 1'b0;
      dealer_win <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state_q)
        StP1: if (step) state_q <= StD1;
        StD1: if (step) state_q <= StP2;
        StP2: if (step) state_q <= StD2;
        StD2: if (step) state_q <= StDec1;
        StDec1: begin
          if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) begin
            state_q <= StScore;
          end else if (pscore <= PLAYER_DRAW_MAX) begin
            state_q <= StP3;
          end else if (dscore <= DEALER_DRAW_MAX) begin
            state_q <= StD3;
          end else begin
            state_q <= StScore;
          end
        end
        StP3:   if (step) state_q <= StDec2;
        StDec2: state_q <= dealer_draw ? StD3 : StScore;
        StD3:   if (step) state_q <= StScore;
        StScore: begin
          player_win <= (pscore >= dscore);
          dealer_win <= (dscore >= pscore);
          done       <= 1'b1;
          state_q    <= StDone;
        end
        StDone: state_q <= StDone;
        default: state_q <= StP1;
      endcase
    end
  end

endmodule

// File: tb/tb_deal_sequencer.sv
// Self-checking bench for deal_sequencer: emulates the card datapath and
// predicts each hand's strobe sequence and winner from the baccarat rules.
module tb_deal_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       step;
  logic [3:0] pscore, dscore, pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win, dealer_win, done;
  logic [5:0] strobes;

  int vectors     = 0;
  int miscompares = 0;
  int psum, dsum;

  localparam logic [5:0] SP1 = 6'b100000;
  localparam logic [5:0] SD1 = 6'b010000;
  localparam logic [5:0] SP2 = 6'b001000;
  localparam logic [5:0] SD2 = 6'b000100;
  localparam logic [5:0] SP3 = 6'b000010;
  localparam logic [5:0] SD3 = 6'b000001;

  deal_sequencer #(
    .CARD_W (4),
    .SCORE_W(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .step       (step),
    .pscore     (pscore),
    .dscore     (dscore),
    .pcard3     (pcard3),
    .load_pcard1(load_pcard1),
    .load_pcard2(load_pcard2),
    .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1),
    .load_dcard2(load_dcard2),
    .load_dcard3(load_dcard3),
    .player_win (player_win),
    .dealer_win (dealer_win),
    .done       (done)
  );

  always #5 clk = ~clk;

  assign strobes = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int val(input int rank);
    return (rank >= 10) ? 0 : rank;
  endfunction

  // Dealer draw thresholds on the player's third card climb by two per dealer point.
  function automatic bit banker_draws(input int d, input int v);
    if (d <= 2) return 1'b1;
    if (d >= 7) return 1'b0;
    if (d == 3) return v != 8;
    return (v >= 2 * (d - 3)) && (v <= 7);
  endfunction

  task automatic dp_drive();
    pscore = 4'(psum % 10);
    dscore = 4'(dsum % 10);
  endtask

  task automatic dp_reset();
    psum   = 0;
    dsum   = 0;
    pcard3 = 4'd0;
    dp_drive();
  endtask

  task automatic capture(input logic [5:0] s, input logic [3:0] rank);
    if (s == SP1 || s == SP2 || s == SP3) psum += val(int'(rank));
    else dsum += val(int'(rank));
    if (s == SP3) pcard3 = rank;
    dp_drive();
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic step_expect(input string tag, input logic [5:0] exp, input logic [3:0] rank);
    step = 1'b1;
    @(negedge clk);
    check_eq(tag, 32'(strobes), 32'(exp));
    @(posedge clk);
    #1 step = 1'b0;
    if (exp != 6'd0) capture(exp, rank);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check_eq("idle_strobe", 32'(strobes), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle decision state: either sit idle or fire a step that must be dropped.
  task automatic pass_decision();
    if ($urandom_range(0, 1) == 1) step_expect("dec_step_dropped", 6'd0, 4'd0);
    else idle(1);
  endtask

  task automatic do_reset(input bit with_step);
    reset = 1'b1;
    step  = with_step;
    dp_reset();
    @(negedge clk);
    check_eq("reset_strobe", 32'(strobes), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    step = 1'b0;
    check_eq("reset_lights", 32'({player_win, dealer_win}), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
  endtask

  task automatic play_hand(input logic [3:0] p1, d1, p2, d2, p3, d3, input bit abort);
    int  p, d, n;
    bit  nat, pdraw, ddraw;
    logic [1:0] lights;
    p     = (val(int'(p1)) + val(int'(p2))) % 10;
    d     = (val(int'(d1)) + val(int'(d2))) % 10;
    nat   = (p >= 8) || (d >= 8);
    pdraw = !nat && (p <= 5);
    if (pdraw) ddraw = banker_draws(d, val(int'(p3)));
    else ddraw = !nat && (d <= 5);
    if (pdraw) p = (p + val(int'(p3))) % 10;
    if (ddraw) d = (d + val(int'(d3))) % 10;

    do_reset(1'($urandom_range(0, 1)));
    step_expect("p1", SP1, p1);
    idle($urandom_range(0, 2));
    step_expect("d1", SD1, d1);
    idle($urandom_range(0, 2));
    step_expect("p2", SP2, p2);
    idle($urandom_range(0, 2));
    step_expect("d2", SD2, d2);
    pass_decision();
    if (pdraw) begin
      idle($urandom_range(0, 2));
      if (abort) begin
        reset = 1'b1;
        step  = 1'b1;
        @(negedge clk);
        check_eq("abort_strobe", 32'(strobes), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        step = 1'b0;
        dp_reset();
        check_eq("abort_lights", 32'({player_win, dealer_win}), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        step_expect("abort_p1", SP1, p1);
        return;
      end
      step_expect("p3", SP3, p3);
      pass_decision();
    end
    if (ddraw) begin
      idle($urandom_range(0, 2));
      step_expect("d3", SD3, d3);
    end
    // Now in the scoring cycle; done must follow on the next edge.
    n = 0;
    while (!done && n < 8) begin
      @(posedge clk);
      #1 n++;
    end
    check_eq("done_latency", 32'(n), 32'd1);
    lights = {1'(p >= d), 1'(d >= p)};
    check_eq("lights", 32'({player_win, dealer_win}), 32'(lights));
    step_expect("done_step", 6'd0, 4'd0);
    idle(1);
    step_expect("done_step", 6'd0, 4'd0);
    check_eq("lights_hold", 32'({player_win, dealer_win}), 32'(lights));
    check_eq("done_hold", 32'(done), 32'd1);
  endtask

  initial begin
    logic [3:0] pc_set [5];
    logic [3:0] dc;
    pc_set = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd12};
    reset  = 1'b1;
    step   = 1'b0;
    dp_reset();
    @(posedge clk);
    #1;

    play_hand(4'd5, 4'd1, 4'd3, 4'd2, 4'd9, 4'd9, 1'b0);    // natural 8 vs 3
    play_hand(4'd6, 4'd4, 4'd10, 4'd13, 4'd1, 4'd5, 1'b0);  // player stands, dealer to 9
    play_hand(4'd3, 4'd7, 4'd4, 4'd10, 4'd1, 4'd1, 1'b0);   // 7-7 tie
    foreach (pc_set[i]) begin
      for (int ds = 0; ds < 8; ds++) begin
        dc = (ds == 0) ? 4'd10 : 4'(ds);
        play_hand(4'd1, dc, 4'd2, 4'd10, pc_set[i], 4'($urandom_range(1, 13)), 1'b0);
      end
    end
    play_hand(4'd1, 4'd2, 4'd2, 4'd10, 4'd5, 4'd5, 1'b1);   // reset while in P3
    repeat (60) begin
      play_hand(4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)),
                4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)),
                4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)),
                ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
